writeback_stage: RTL and testbench

- Final pipeline stage; sits directly downstream of the memory stage and consumes its registered outputs.
- Selects the value to retire to the register file: load data for regWrtSrc 0, otherwise the precomputed data.
- Drives the register-file write port and keeps a short history of recent retired writes for forwarding to decode.
- Tracks a sticky error, a retire counter, and a halt-drain state machine that signals when the pipeline has quiesced.

---
 rtl/writeback_stage_if.sv | 44 ++++
 rtl/writeback_stage.sv | 145 ++++++++++++++
 tb/tb_writeback_stage.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: memory-stage inputs, register-file write port,
// forwarding lookup and status outputs.
interface writeback_stage_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      memOut;
  logic [15:0]      regWriteData;
  logic             regWrtEn;
  logic [2:0]       writeReg;
  logic [2:0]       regWrtSrc;
  logic             errIn;
  logic             haltIn;
  logic             dMemStall;
  logic [2:0]       rdReg1;
  logic [2:0]       rdReg2;
  logic             rfWrt;
  logic [2:0]       rfWrtReg;
  logic [15:0]      rfWrtData;
  logic             fwd1Hit;
  logic [15:0]      fwd1Data;
  logic             fwd2Hit;
  logic [15:0]      fwd2Data;
  logic             err;
  logic             haltDone;
  logic [CNT_W-1:0] retireCnt;

  modport slave (
    input  memOut, regWriteData, regWrtEn,
    input  writeReg, regWrtSrc, errIn,
    input  haltIn, dMemStall, rdReg1, rdReg2,
    output rfWrt, rfWrtReg, rfWrtData,
    output fwd1Hit, fwd1Data, fwd2Hit, fwd2Data,
    output err, haltDone, retireCnt
  );

  modport master (
    output memOut, regWriteData, regWrtEn,
    output writeReg, regWrtSrc, errIn,
    output haltIn, dMemStall, rdReg1, rdReg2,
    input  rfWrt, rfWrtReg, rfWrtData,
    input  fwd1Hit, fwd1Data, fwd2Hit, fwd2Data,
    input  err, haltDone, retireCnt
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: register-file write port, retired-write history
// for forwarding, sticky error, retire counter and halt drain FSM.
module writeback_stage #(
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       drainCnt;
  logic             errQ;
  logic             haltQ;
  logic [CNT_W-1:0] cntQ;

  logic        histV [HIST_DEPTH];
  logic [2:0]  histR [HIST_DEPTH];
  logic [15:0] histD [HIST_DEPTH];

  logic [15:0] wbData;
  logic        retire;
  logic        illegal;
  logic        hit1, hit2;
  logic [15:0] dat1, dat2;

  assign wbData = (bus.regWrtSrc == 3'd0)
                ? bus.memOut : bus.regWriteData;
  assign illegal = bus.regWrtEn
                 & (bus.regWrtSrc == 3'd7);
  assign retire = rst & bus.regWrtEn
                & ~bus.dMemStall
                & (bus.regWrtSrc != 3'd7)
                & (state != HALTED);

  assign bus.rfWrt     = retire;
  assign bus.rfWrtReg  = bus.writeReg;
  assign bus.rfWrtData = wbData;
  assign bus.err       = errQ;
  assign bus.haltDone  = haltQ;
  assign bus.retireCnt = cntQ;
  assign bus.fwd1Hit   = hit1;
  assign bus.fwd1Data  = dat1;
  assign bus.fwd2Hit   = hit2;
  assign bus.fwd2Data  = dat2;

  // Oldest-first scan so newer matches overwrite; live retire wins last.
  always_comb begin
    hit1 = 1'b0;
    dat1 = 16'h0;
    hit2 = 1'b0;
    dat2 = 16'h0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (histV[i] && histR[i] == bus.rdReg1) begin
        hit1 = 1'b1;
        dat1 = histD[i];
      end
      if (histV[i] && histR[i] == bus.rdReg2) begin
        hit2 = 1'b1;
        dat2 = histD[i];
      end
    end
    if (retire && bus.writeReg == bus.rdReg1) begin
      hit1 = 1'b1;
      dat1 = wbData;
    end
    if (retire && bus.writeReg == bus.rdReg2) begin
      hit2 = 1'b1;
      dat2 = wbData;
    end
  end

  // History shifts on retire, ages when idle, freezes on stall/halt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        histV[i] <= 1'b0;
        histR[i] <= 3'd0;
        histD[i] <= 16'h0;
      end
    end else if (retire
             || (!bus.dMemStall && state != HALTED)) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        histV[i] <= histV[i-1];
        histR[i] <= histR[i-1];
        histD[i] <= histD[i-1];
      end
      histV[0] <= retire;
      histR[0] <= bus.writeReg;
      histD[0] <= wbData;
    end
  end

  // Sticky error and wrapping retire counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      errQ <= 1'b0;
      cntQ <= '0;
    end else begin
      if (state != HALTED && (bus.errIn || illegal))
        errQ <= 1'b1;
      if (retire)
        cntQ <= cntQ + 1'b1;
    end
  end

  // Halt drain: wait HIST_DEPTH unstalled edges, then freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      drainCnt <= 3'd0;
      haltQ    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.haltIn) begin
            state    <= DRAIN;
            drainCnt <= 3'(HIST_DEPTH);
          end
        end
        DRAIN: begin
          if (!bus.dMemStall) begin
            if (drainCnt == 3'd1) begin
              state <= HALTED;
              haltQ <= 1'b1;
            end
            drainCnt <= drainCnt - 3'd1;
          end
        end
        default: begin
          state <= HALTED;
          haltQ <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed steps plus a
// random phase against a queue-based reference model.
module tb_writeback_stage;
  localparam int HD = 2;

  typedef struct packed {
    logic        v;
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  writeback_stage_if #(.CNT_W(16)) bus ();

  writeback_stage #(.HIST_DEPTH(HD), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ent_t    hist[$];
  int      mode;
  int      left;
  logic    mErr;
  int      mCnt;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic expRetire();
    return rst && bus.regWrtEn && !bus.dMemStall
        && bus.regWrtSrc != 3'd7 && mode != 2;
  endfunction

  function automatic logic [15:0] expWb();
    return (bus.regWrtSrc == 3'd0)
         ? bus.memOut : bus.regWriteData;
  endfunction

  task automatic lookup(input logic [2:0] rd,
                        output logic hit,
                        output logic [15:0] d);
    hit = 1'b0;
    d = 16'h0;
    if (expRetire() && bus.writeReg == rd) begin
      hit = 1'b1;
      d = expWb();
      return;
    end
    foreach (hist[i]) begin
      if (hist[i].v && hist[i].r == rd) begin
        hit = 1'b1;
        d = hist[i].d;
        return;
      end
    end
  endtask

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < HD; i++) hist.push_back('0);
    mode = 0;
    left = 0;
    mErr = 1'b0;
    mCnt = 0;
  endtask

  task automatic settle();
    logic h;
    logic [15:0] d;
    #2;
    chk("rfWrt", 32'(bus.rfWrt), 32'(expRetire()));
    chk("rfWrtReg", 32'(bus.rfWrtReg), 32'(bus.writeReg));
    chk("rfWrtData", 32'(bus.rfWrtData), 32'(expWb()));
    lookup(bus.rdReg1, h, d);
    chk("fwd1Hit", 32'(bus.fwd1Hit), 32'(h));
    chk("fwd1Data", 32'(bus.fwd1Data), 32'(d));
    lookup(bus.rdReg2, h, d);
    chk("fwd2Hit", 32'(bus.fwd2Hit), 32'(h));
    chk("fwd2Data", 32'(bus.fwd2Data), 32'(d));
    chk("err", 32'(bus.err), 32'(mErr));
    chk("haltDone", 32'(bus.haltDone), 32'(mode == 2));
    chk("retireCnt", 32'(bus.retireCnt), 32'(mCnt));
  endtask

  task automatic edgeStep();
    logic r;
    r = expRetire();
    @(posedge clk);
    if (!rst) begin
      modelReset();
    end else begin
      if (r) begin
        hist.push_front({1'b1, bus.writeReg, expWb()});
        void'(hist.pop_back());
        mCnt = (mCnt + 1) % 65536;
      end else if (!bus.dMemStall && mode != 2) begin
        hist.push_front('0);
        void'(hist.pop_back());
      end
      if (mode != 2 && (bus.errIn
          || (bus.regWrtEn && bus.regWrtSrc == 3'd7)))
        mErr = 1'b1;
      if (mode == 0 && bus.haltIn) begin
        mode = 1;
        left = HD;
      end else if (mode == 1 && !bus.dMemStall) begin
        if (left == 1) mode = 2;
        else left--;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    edgeStep();
  endtask

  task automatic idle();
    bus.regWrtEn = 1'b0;
    bus.regWrtSrc = 3'd1;
    bus.errIn = 1'b0;
    bus.haltIn = 1'b0;
    bus.dMemStall = 1'b0;
  endtask

  task automatic wr(logic [2:0] rg, logic [15:0] d);
    idle();
    bus.regWrtEn = 1'b1;
    bus.writeReg = rg;
    bus.regWriteData = d;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    modelReset();
    rst = 1'b0;
    bus.memOut = 16'h0;
    bus.regWriteData = 16'h0;
    bus.writeReg = 3'd0;
    bus.rdReg1 = 3'd0;
    bus.rdReg2 = 3'd0;
    idle();
    bus.regWrtEn = 1'b1;
    #1;
    edgeStep();
    cyc();
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_halt", 32'(bus.haltDone), 32'd0);
    chk("rst_cnt", 32'(bus.retireCnt), 32'd0);
    chk("rst_fwd", 32'(bus.fwd1Hit), 32'd0);

    rst = 1'b1;
    wr(3'd3, 16'h1234);
    bus.regWrtSrc = 3'd0;
    bus.memOut = 16'hBEEF;
    settle();
    chk("load", 32'(bus.rfWrtData), 32'h0000BEEF);
    edgeStep();
    bus.regWrtSrc = 3'd1;
    settle();
    chk("alu", 32'(bus.rfWrtData), 32'h00001234);
    edgeStep();
    idle();
    cyc();
    chk("cnt2", 32'(bus.retireCnt), 32'd2);

    wr(3'd5, 16'h0011);
    cyc();
    wr(3'd5, 16'h0022);
    cyc();
    idle();
    bus.rdReg1 = 3'd5;
    bus.rdReg2 = 3'd5;
    settle();
    chk("fwdNew", 32'(bus.fwd1Data), 32'h22);
    chk("fwdHit", 32'(bus.fwd1Hit), 32'd1);
    edgeStep();
    for (int i = 0; i < HD - 1; i++) cyc();
    settle();
    chk("fwdAged", 32'(bus.fwd1Hit), 32'd0);
    chk("fwdAgedD", 32'(bus.fwd1Data), 32'd0);
    edgeStep();

    wr(3'd2, 16'hAAAA);
    cyc();
    wr(3'd2, 16'h5555);
    bus.dMemStall = 1'b1;
    bus.rdReg1 = 3'd2;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stallWr", 32'(bus.rfWrt), 32'd0);
      chk("stallHist", 32'(bus.fwd1Data), 32'hAAAA);
      chk("stallCnt", 32'(bus.retireCnt), 32'd5);
      edgeStep();
    end
    bus.dMemStall = 1'b0;
    cyc();
    idle();
    cyc();
    chk("relCnt", 32'(bus.retireCnt), 32'd6);

    wr(3'd1, 16'h0001);
    bus.regWrtSrc = 3'd7;
    settle();
    chk("illWr", 32'(bus.rfWrt), 32'd0);
    edgeStep();
    idle();
    cyc();
    chk("illErr", 32'(bus.err), 32'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    bus.errIn = 1'b1;
    cyc();
    bus.errIn = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("errSticky", 32'(bus.err), 32'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("errClr", 32'(bus.err), 32'd0);

    wr(3'd4, 16'h0C0C);
    bus.haltIn = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < HD; i++) begin
      chk("drain", 32'(bus.haltDone), 32'd0);
      cyc();
    end
    chk("halted", 32'(bus.haltDone), 32'd1);
    wr(3'd4, 16'h0D0D);
    settle();
    chk("haltWr", 32'(bus.rfWrt), 32'd0);
    edgeStep();
    rst = 1'b0;
    idle();
    cyc();
    rst = 1'b1;
    bus.haltIn = 1'b1;
    cyc();
    idle();
    bus.dMemStall = 1'b1;
    cyc();
    cyc();
    bus.dMemStall = 1'b0;
    for (int i = 0; i < HD; i++) begin
      chk("drainSt", 32'(bus.haltDone), 32'd0);
      cyc();
    end
    chk("haltedSt", 32'(bus.haltDone), 32'd1);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 40) != 0);
      bus.memOut = 16'($urandom);
      bus.regWriteData = 16'($urandom);
      bus.regWrtEn = ($urandom_range(0, 3) != 0);
      bus.writeReg = 3'($urandom);
      bus.regWrtSrc = 3'($urandom);
      bus.errIn = ($urandom_range(0, 30) == 0);
      bus.haltIn = ($urandom_range(0, 25) == 0);
      bus.dMemStall = ($urandom_range(0, 4) == 0);
      bus.rdReg1 = 3'($urandom);
      bus.rdReg2 = 3'($urandom);
      cyc();
    end

    rst = 1'b0;
    idle();
    cyc();
    rst = 1'b1;
    wr(3'd6, 16'h0);
    for (int n = 0; n < 65535; n++) begin
      bus.regWriteData = 16'(n);
      bus.rdReg1 = 3'($urandom);
      cyc();
    end
    settle();
    chk("cntMax", 32'(bus.retireCnt), 32'hFFFF);
    edgeStep();
    idle();
    settle();
    chk("cntWrap", 32'(bus.retireCnt), 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
